// File: rtl/flash_read_controller_if.sv
// Request/response bundle between a requester and the serial-flash read controller.
// Latency: none, wires only.
// Backpressure: req_ready gates requests; data_valid/done are pulses with no backpressure.
interface flash_read_controller_if #(
  parameter int LengthBitWidth = 16
) ();
  logic                      req_valid;
  logic                      req_ready;
  logic [23:0]               req_address;
  logic [LengthBitWidth-1:0] req_length;
  logic                      data_valid;
  logic [7:0]                data_out;
  logic                      done;
  logic                      busy;

  // Requester side (boot / cache-fill logic)
  modport master (
    output req_valid, req_address, req_length,
    input  req_ready, data_valid, data_out, done, busy
  );

  // Controller side
  modport slave (
    input  req_valid, req_address, req_length,
    output req_ready, data_valid, data_out, done, busy
  );
endinterface

// File: rtl/flash_read_controller.sv
// SPI mode-0 master issuing READ (0x03) + 24-bit address, streaming N bytes back.
// Latency: byte k valid the cycle after edge T+80+16k (T = accept edge); done with the last byte.
// Backpressure: req_ready low while busy or deselecting; data_valid has none, consumer must keep up.
module flash_read_controller #(
  parameter int LengthBitWidth = 16,
  parameter int CsHighCycles   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  flash_read_controller_if.slave  bus,
  output logic                    spi_sclk,
  output logic                    spi_cs_n,
  output logic                    spi_mosi,
  input  logic                    spi_miso
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DESEL
  } state_t;

  localparam logic [7:0]                ReadCmd  = 8'h03;
  localparam logic [3:0]                DselLast = 4'(CsHighCycles - 1);
  localparam logic [LengthBitWidth-1:0] LenOne   = LengthBitWidth'(1);

  state_t                    state_q, state_d;
  logic                      phase_q, phase_d;     // 0: sclk low half, 1: sclk high half
  logic [4:0]                bit_cnt_q, bit_cnt_d; // 0..31 over cmd+addr, 0..7 within a data byte
  logic [31:0]               sr_q, sr_d;           // outgoing command+address, MSB leaves first
  logic [7:0]                rx_q, rx_d;
  logic [LengthBitWidth-1:0] len_q, len_d;         // bytes still to receive
  logic [3:0]                dsel_q, dsel_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      dv_q, dv_d;
  logic [7:0]                dout_q, dout_d;
  logic                      done_q, done_d;
  logic                      sclk_q, sclk_d;
  logic                      cs_n_q, cs_n_d;
  logic                      mosi_q, mosi_d;

  // Next-state and next-output computation for the read sequencer
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    rx_d      = rx_q;
    len_d     = len_q;
    dsel_d    = dsel_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    dv_d      = 1'b0;
    dout_d    = dout_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (bus.req_length == '0) begin
            // Empty request: complete immediately without touching the flash
            state_d = DESEL;
            dsel_d  = '0;
            done_d  = 1'b1;
          end else begin
            state_d   = CMD;
            len_d     = bus.req_length;
            sr_d      = {ReadCmd, bus.req_address};
            cs_n_d    = 1'b0;
            mosi_d    = ReadCmd[7];
            sclk_d    = 1'b0;
            phase_d   = 1'b0;
            bit_cnt_d = '0;
          end
        end
      end

      CMD, ADDR: begin
        if (!phase_q) begin
          sclk_d  = 1'b1;
          phase_d = 1'b1;
        end else begin
          // Falling sclk: present the next outgoing bit
          sclk_d    = 1'b0;
          phase_d   = 1'b0;
          sr_d      = {sr_q[30:0], 1'b0};
          mosi_d    = sr_q[30];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            state_d = ADDR;
          end
          if (bit_cnt_q == 5'd31) begin
            state_d   = DATA;
            mosi_d    = 1'b0;
            bit_cnt_d = '0;
          end
        end
      end

      DATA: begin
        if (!phase_q) begin
          sclk_d  = 1'b1;
          phase_d = 1'b1;
        end else begin
          // Falling sclk: the flash bit has been stable through the high half
          sclk_d    = 1'b0;
          phase_d   = 1'b0;
          rx_d      = {rx_q[6:0], spi_miso};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q[2:0] == 3'd7) begin
            dv_d      = 1'b1;
            dout_d    = {rx_q[6:0], spi_miso};
            len_d     = len_q - LenOne;
            bit_cnt_d = '0;
            if (len_q == LenOne) begin
              done_d  = 1'b1;
              cs_n_d  = 1'b1;
              state_d = DESEL;
              dsel_d  = '0;
            end
          end
        end
      end

      DESEL: begin
        if (dsel_q == DselLast) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          dsel_d = dsel_q + 4'd1;
        end
      end

      default: begin
        state_d = DESEL;
        dsel_d  = '0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops cs_n/sclk at once and starts in deselect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DESEL;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      rx_q      <= '0;
      len_q     <= '0;
      dsel_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      dv_q      <= 1'b0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      rx_q      <= rx_d;
      len_q     <= len_d;
      dsel_q    <= dsel_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      dv_q      <= dv_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.data_valid = dv_q;
  assign bus.data_out   = dout_q;
  assign bus.done       = done_q;
  assign spi_sclk       = sclk_q;
  assign spi_cs_n       = cs_n_q;
  assign spi_mosi       = mosi_q;

endmodule

// File: doc/flash_read_controller.md
# flash_read_controller

SPI master that sequences sequential-read transactions on the external serial flash (P25Q32U, READ command 0x03, 24-bit address). It accepts a request (start address, byte count) over a valid/ready handshake and drives the flash pins. It then streams the returned bytes to the requester, one pulse per byte. It sits between the boot/cache-fill logic and the flash pins (or the flash emulator in simulation).

## Interface

- LengthBitWidth, 16, width of the byte-count field; maximum transfer is 2^LengthBitWidth-1 bytes
- CsHighCycles, 2, minimum clk cycles spi_cs_n stays high between transactions (1..15)
- clk  input  1  system clock; SPI clock is clk/2
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  controller idle and able to accept
- req_address  input  24  flash byte address of first byte
- req_length  input  LengthBitWidth  number of bytes to read
- data_valid  output  1  one-cycle pulse: data_out holds a new byte
- data_out  output  8  received byte, MSB first on wire
- done  output  1  one-cycle pulse: transaction complete
- busy  output  1  transaction in progress (not Idle)
- spi_sclk  output  1  flash serial clock, idles low (SPI mode 0)
- spi_cs_n  output  1  flash chip select, active low
- spi_mosi  output  1  controller to flash
- spi_miso  input  1  flash to controller

## Operation

- All outputs are registered.
- Reset values: req_ready=0, busy=0, data_valid=0, data_out=0, done=0, spi_sclk=0, spi_cs_n=1, spi_mosi=0.
- After reset, the controller enters Deselect, so req_ready first rises CsHighCycles cycles after rst_n deasserts.
- States:
  - Idle: req_ready=1. On req_valid&&req_ready, latch address and length, then go to Command. If length==0, go to Deselect instead, with done pulsed in the next cycle and no SPI activity.
  - Command: shift out 8 bits of 0x03, MSB first, then go to Address.
  - Address: shift out 24 address bits, MSB first, then go to Data.
  - Data: shift in 8 bits per byte, MSB first. Pulse data_valid per byte and decrement the remaining-byte counter. After the last byte, go to Deselect.
  - Deselect: spi_cs_n=1 for CsHighCycles cycles, then go to Idle.
- Bit timing uses two clk cycles per bit:
  - Phase 0: spi_sclk=0, spi_mosi holds the current bit.
  - Phase 1: spi_sclk=1.
  - The flash samples mosi on the sclk rising edge.
  - The controller samples spi_miso on the clk edge that ends phase 1 (sclk falling).
- spi_mosi=0 throughout Data.
- req_valid while busy is ignored. The request is not latched and no error is raised.
- There is no backpressure on data_valid; the consumer must take every pulse.
- Address wrap at 0xFFFFFF is the flash's behaviour. The controller never re-sends an address.
- The byte counter is LengthBitWidth wide and decrements with no wrap. The terminal condition is counter==1 at byte completion.
- Reset mid-transaction: spi_cs_n goes high and spi_sclk low immediately (async). The transaction is abandoned, with no done and no data_valid.

## Timing

- Handshake accepted at clk edge T:
  - After T: spi_cs_n=0, spi_mosi=0 (bit 7 of 0x03), spi_sclk=0, busy=1, req_ready=0.
- Bit n (0-based across command, address and data) occupies the cycles after edges T+2n and T+2n+1, and ends at edge T+2n+2.
- Data byte k (0-based) is sampled by edge T+80+16k. data_valid is high with the byte on data_out for the single cycle after that edge.
- Last byte (k=N-1), at edge T+64+16N:
  - data_valid=1 and done=1 for one cycle.
  - spi_cs_n=1, spi_sclk=0.
  - State becomes Deselect.
- req_ready=1 from the cycle after edge T+64+16N+CsHighCycles.
  - Back-to-back minimum request period is 64+16N+CsHighCycles+1 cycles.
- length==0: done=1 in the cycle after T; req_ready returns CsHighCycles cycles later; spi_cs_n never falls.
- spi_sclk never has a high pulse while spi_cs_n=1.

## Test plan

- Flash emulator preloaded with byte 0xA5 at address 0x000010; request addr=0x000010, len=1 -> mosi bits carry 0x03,0x00,0x00,0x10; data_out=0xA5 with data_valid in the cycle after T+80; done in the same cycle; spi_cs_n high for 2 cycles before req_ready.
- Request addr=0x000100, len=4 over bytes 0x11,0x22,0x33,0x44 -> four data_valid pulses after edges T+80, T+96, T+112, T+128, in order; done with the 4th pulse; exactly 64 sclk rising edges.
- Request len=0 -> done pulse in the cycle after acceptance; no spi_cs_n low; req_ready back after 2 cycles.
- req_valid held high with alternating addresses during a transfer -> only the first request is served; the next is accepted only when req_ready returns; cs_n high gap is at least CsHighCycles.
- rst_n asserted at T+40 during a 2-byte read -> spi_cs_n=1 and spi_sclk=0 immediately; no data_valid or done; a new len=1 request afterwards returns the correct byte.
- Request addr=0xFFFFFE, len=3 -> data matches flash bytes at 0xFFFFFE, 0xFFFFFF, 0x000000; no extra address phase.
